// File: rtl/pio_in_edge_irq_pkg.sv
// Shared constants for the edge-capturing input PIO.
// Register addresses, edge select and irq mode encodings.
package pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

    // Debounce counter width; at least one bit even when bypassed.
    function automatic int cnt_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/pio_in_edge_irq_if.sv
// Avalon-MM slave bus bundle for the input PIO.
// Read data comes back one cycle after the address.
interface pio_in_edge_irq_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/pio_debounce_bit.sv
// One input bit: synchroniser chain, debounce counter and accepted level.
// A new level is taken only after DEBOUNCE_CYCLES consecutive agreeing samples.
module pio_debounce_bit #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic stable
);
    import pio_pkg::*;

    logic [SYNC_STAGES-1:0] sff;
    logic                   sync;

    // Metastability chain for the asynchronous pin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sff <= '0;
        end else begin
            sff <= {sff[SYNC_STAGES-2:0], din};
        end
    end

    assign sync = sff[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            // No filtering: follow the synchronised input directly.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    stable <= 1'b0;
                end else begin
                    stable <= sync;
                end
            end
        end else begin : g_deb
            localparam int CW = cnt_width(DEBOUNCE_CYCLES);
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt;

            // Count disagreeing cycles; any agreement restarts the count.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt    <= '0;
                    stable <= 1'b0;
                end else if (sync == stable) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    stable <= sync;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/pio_in_edge_irq.sv
// Debounced input PIO with edge capture, irq mask and W1C clear.
// Read data is registered every cycle from the addressed register.
module pio_in_edge_irq #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_TYPE       = 0,
    parameter int IRQ_MODE        = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    pio_in_edge_irq_if.slave    bus,
    input  logic [WIDTH-1:0]    in_port,
    output logic                irq
);
    import pio_pkg::*;

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] wdata;
    logic [31:0]      rd_mux;
    logic             wr;
    logic             mask_we;
    logic             edge_we;
    logic             unused_wdata;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            pio_debounce_bit #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clk    (clk),
                .reset_n(reset_n),
                .din    (in_port[gi]),
                .stable (stable[gi])
            );
        end
    endgenerate

    assign wr      = bus.chipselect & ~bus.write_n;
    assign mask_we = wr && (bus.address == ADDR_MASK);
    assign edge_we = wr && (bus.address == ADDR_EDGE);
    assign wdata   = bus.writedata[WIDTH-1:0];
    assign clr     = edge_we ? wdata : '0;

    // Bits above WIDTH are don't-care on writes.
    assign unused_wdata = &{1'b0, bus.writedata};

    assign rise = stable & ~prev;
    assign fall = ~stable & prev;

    // Select which transition of the debounced level is captured.
    always_comb begin
        edge_det = rise;
        if (EDGE_TYPE == EDGE_FALL) begin
            edge_det = fall;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            edge_det = rise | fall;
        end
    end

    // Delayed copy of the debounced level for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev <= '0;
        end else begin
            prev <= stable;
        end
    end

    // Interrupt mask register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask <= '0;
        end else if (mask_we) begin
            irqmask <= wdata;
        end
    end

    // Sticky edge flags; a new edge beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecap <= '0;
        end else begin
            edgecap <= (edgecap & ~clr) | edge_det;
        end
    end

    // Read mux; unused upper bits and the reserved word read 0.
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA: rd_mux[WIDTH-1:0] = stable;
            ADDR_MASK: rd_mux[WIDTH-1:0] = irqmask;
            ADDR_EDGE: rd_mux[WIDTH-1:0] = edgecap;
            default:   rd_mux = '0;
        endcase
    end

    // Fixed one-cycle read latency, no chipselect qualification.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else begin
            bus.readdata <= rd_mux;
        end
    end

    generate
        if (IRQ_MODE == IRQ_LEVEL) begin : g_irq_lvl
            assign irq = |(stable & irqmask);
        end else begin : g_irq_edge
            assign irq = |(edgecap & irqmask);
        end
    endgenerate

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Directed bench for the debounced edge-capture input PIO.
// All driving and sampling happens on the falling clock edge.
module tb_pio_in_edge_irq;

    logic       clk;
    logic       reset_n;
    logic [3:0] in_port;
    logic       irq;
    logic [31:0] rdv;
    logic       seen;

    int total = 0;
    int bad   = 0;

    pio_in_edge_irq_if bus ();

    pio_in_edge_irq #(
        .WIDTH          (4),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(16),
        .EDGE_TYPE      (0),
        .IRQ_MODE       (1)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus),
        .in_port(in_port),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.address = a;
        @(negedge clk);
        d = bus.readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
    endtask

    initial begin
        reset_n        = 1'b0;
        in_port        = 4'b0000;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        tick(3);
        chk("rst_rdata", bus.readdata, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        reset_n = 1'b1;
        tick(2);

        for (int a = 0; a < 4; a++) begin
            rd(2'(a), rdv);
            chk($sformatf("idle_rd%0d", a), rdv, 32'h0);
        end
        chk("idle_irq", {31'h0, irq}, 32'h0);

        wr(2'd2, 32'h1);
        rd(2'd2, rdv);
        chk("mask_rd", rdv, 32'h1);

        in_port = 4'b0001;
        tick(18);
        chk("b0_irq_c18", {31'h0, irq}, 32'h0);
        tick(1);
        chk("b0_irq_c19", {31'h0, irq}, 32'h1);
        rd(2'd0, rdv);
        chk("b0_data", rdv, 32'h1);
        rd(2'd3, rdv);
        chk("b0_edge", rdv, 32'h1);

        wr(2'd3, 32'h1);
        chk("b0_clr_irq", {31'h0, irq}, 32'h0);
        rd(2'd3, rdv);
        chk("b0_clr_edge", rdv, 32'h0);

        wr(2'd2, 32'hF);
        in_port = 4'b0011;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen |= irq;
        end
        in_port = 4'b0001;
        repeat (30) begin
            @(negedge clk);
            seen |= irq;
        end
        chk("glitch_irq", {31'h0, seen}, 32'h0);
        rd(2'd0, rdv);
        chk("glitch_data", rdv, 32'h1);
        rd(2'd3, rdv);
        chk("glitch_edge", rdv, 32'h0);
        wr(2'd2, 32'h1);

        in_port = 4'b0000;
        tick(30);
        rd(2'd3, rdv);
        chk("fall_ignored", rdv, 32'h0);
        rd(2'd0, rdv);
        chk("fall_data", rdv, 32'h0);

        in_port = 4'b0101;
        tick(25);
        rd(2'd3, rdv);
        chk("b02_edge", rdv, 32'h5);
        chk("b02_irq", {31'h0, irq}, 32'h1);
        wr(2'd3, 32'h1);
        rd(2'd3, rdv);
        chk("b02_clr_edge", rdv, 32'h4);
        chk("b02_clr_irq", {31'h0, irq}, 32'h0);

        in_port = 4'b0001;
        tick(25);
        in_port = 4'b0101;
        tick(18);
        wr(2'd3, 32'h4);
        rd(2'd3, rdv);
        chk("set_wins", rdv, 32'h4);

        wr(2'd2, 32'h5);
        chk("rd_during_wr", bus.readdata, 32'h1);
        rd(2'd2, rdv);
        chk("mask_new", rdv, 32'h5);
        chk("mask_irq", {31'h0, irq}, 32'h1);

        in_port = 4'b1101;
        tick(10);
        reset_n = 1'b0;
        tick(1);
        chk("mid_rst_rdata", bus.readdata, 32'h0);
        chk("mid_rst_irq", {31'h0, irq}, 32'h0);
        tick(2);
        reset_n = 1'b1;
        wr(2'd2, 32'hF);
        seen = irq;
        repeat (17) begin
            @(negedge clk);
            seen |= irq;
        end
        chk("rst_no_early", {31'h0, seen}, 32'h0);
        tick(1);
        chk("rst_irq_c19", {31'h0, irq}, 32'h1);
        rd(2'd3, rdv);
        chk("rst_edge", rdv, 32'hD);
        rd(2'd1, rdv);
        chk("rsvd_rd", rdv, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
